// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART state encodings and bit-period math (also used by the transmit side)
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_t;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int baud_half(input int clk_hz, input int baud);
        return baud_div(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - synchronous first-word-fall-through byte FIFO with push, pop, full and empty
module rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with read buffer; UART_RX_FIFO_EN selects rx_fifo, else a holding register
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       clr_err,
    output logic       overrun,
    output logic       frame_err
);

    localparam int DIV  = baud_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int HALF = baud_half(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW   = $clog2(DIV);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end

    logic          rxd_m;
    logic          rxd_s;
    uart_state_t   state;
    uart_state_t   state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          push;
    logic          fe_set;
    logic          ovr_set;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        push       = 1'b0;
        fe_set     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxd_s) begin
                    state_next = ST_START;
                    cnt_next   = CW'(HALF - 1);
                end
            end
            ST_START: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (!rxd_s) begin
                    state_next = ST_DATA;
                    cnt_next   = CW'(DIV - 1);
                    bit_next   = 3'd0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    shift_next = {rxd_s, shift[7:1]};
                    cnt_next   = CW'(DIV - 1);
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (rxd_s) begin
                    push       = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    fe_set     = 1'b1;
                    state_next = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (rxd_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef UART_RX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (push),
        .din   (shift),
        .pop   (rd_en),
        .dout  (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rd_valid = ~fifo_empty;
    assign ovr_set  = push & fifo_full & ~rd_en;
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
        end else if (push && (!hold_valid || rd_en)) begin
            hold_valid <= 1'b1;
            hold_data  <= shift;
        end else if (rd_en) begin
            hold_valid <= 1'b0;
        end
    end

    assign rd_valid = hold_valid;
    assign rd_data  = hold_data;
    assign ovr_set  = push & hold_valid & ~rd_en;
`endif

    // A new error event wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= ovr_set | (overrun & ~clr_err);
            frame_err <= fe_set | (frame_err & ~clr_err);
        end
    end

endmodule
